fpcvt_sched: RTL and testbench
==============================

# fpcvt_sched

Round-robin scheduler that shares one FPCVT converter (13-bit two's complement to sign/3-bit exponent/5-bit significand) between NREQ requesters. Each requester presents a sample with a valid/ready handshake. The block grants one requester per cycle and registers the sample ahead of the converter. It registers the converted result, tagged with the requester index, behind the converter. It sits between the sample producers and the display/encoding logic that consumes the floating-point values.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: width of the requester tag; must satisfy 2^IDW >= NREQ.
- clk  in  1  single clock; every register updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert and active-low; see Timing for deassertion.
- req_valid  in  NREQ  bit i high means requester i presents a sample.
- req_data  in  13*NREQ  sample of requester i is bits [13*i+12 : 13*i], two's complement.
- req_ready  out  NREQ  one-hot grant; bit i high means requester i's sample is accepted at this edge.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result at this edge.
- res_id  out  IDW  requester index of the result.
- res_s  out  1  sign.
- res_e  out  3  exponent.
- res_f  out  5  significand.
- busy  out  1  high when either pipeline stage holds valid data.

## Operation
- Stage 1 (input register): s1_v, s1_d[12:0], s1_id.
- Converter: the FPCVT converter, instantiated combinationally on s1_d.
- Stage 2 (result register): res_valid, res_s/e/f, res_id.
- Advance conditions:
  - adv2 = !res_valid | res_ready.
  - adv1 = !s1_v | adv2.
- Grant:
  - Combinational from req_valid and the round-robin pointer ptr[IDW-1:0].
  - When adv1 is high, the block searches indices ptr, ptr+1, … NREQ-1, 0, … ptr-1.
  - It grants the first index with req_valid set, raising exactly that req_ready bit.
  - When adv1 is low, req_ready is all zero.
- Pointer: on a grant to index g, ptr becomes g+1, wrapping to 0 at NREQ. With no grant, ptr holds.
- On a grant, stage 1 loads the granted sample and index and sets s1_v.
- If adv1 is high with no grant, s1_v clears.
- When adv2 is high:
  - Stage 2 loads the converter outputs and s1_id.
  - res_valid takes s1_v.
- When adv2 is low, stage 2 and stage 1 hold unchanged (stall).
- Converter edge cases pass through unchanged:
  - Most negative input (13'h1000) gives S=1, E=7, F=31.
  - Rounding that overflows E saturates to E=7, F=31.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- A requester may drop req_valid without being granted. There is no fairness debt for that.

## Timing
- Reset values (all stage 1 and stage 2 registers):
  - ptr=0, s1_v=0, s1_d=0, s1_id=0.
  - res_valid=0, res_id=0, res_s=0, res_e=0, res_f=0, busy=0.
  - req_ready=0 while rst_n is low.
- Reset deassertion is synchronised externally. Reset mid-operation drops any in-flight samples without producing a result.
- Latency: a sample accepted at edge N has res_valid high after edge N+1, provided stage 2 was free or draining.
- Throughput: one result per cycle while res_ready is held high and some requester is valid.
- Stall: res_valid stays high and res_* stay stable until the edge where res_ready is high.
- Simultaneous drain and refill: when res_ready is high with s1_v set, stage 2 reloads at the same edge without a bubble.
- Full pipeline (both stages valid, res_ready low): req_ready=0 and no ptr update.
- busy = s1_v | res_valid.

## Test plan
- Single requester 0, D=422, res_ready=1 → two cycles later: res_id=0, S=0, E=4, F=26.
- Requesters 0..3 all valid continuously, with samples 63, -1 (13'h1FFF), 56, 13'h1000 → grants in order 0,1,2,3,0…, with these results:
  - E=2, F=16;
  - S=1, E=0, F=1;
  - E=1, F=28;
  - S=1, E=7, F=31.
- Backpressure: fill both stages, hold res_ready=0 for 5 cycles → req_ready stays 0, res_* stay stable, ptr is unchanged. Raising res_ready then gives one result per cycle with no loss and no duplication.
- Fairness: requesters 1 and 3 valid continuously, ptr=0 → grants alternate 1,3,1,3. Adding requester 2 mid-stream → order becomes 1,2,3,1 after the next grant to 1.
- Edge value D=13'h0FFF → S=0, E=7, F=31 (saturation).
- Reset asserted while both stages are valid → res_valid and busy go low immediately (asynchronously). After release, the first grant goes to the lowest valid index from ptr=0.

Source files
------------

// File: rtl/fpcvt_sched_if.sv
// Request/result bundle for the shared FPCVT scheduler.
// The slave modport is the scheduler; the master modport is the
// producer/consumer side.
interface fpcvt_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [13*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [IDW-1:0]       res_id;
  logic                 res_s;
  logic [2:0]           res_e;
  logic [4:0]           res_f;
  logic                 busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_s, res_e, res_f, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_s, res_e, res_f, busy
  );
endinterface

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one 13-bit two's complement to
// sign/3-bit exponent/5-bit significand converter between NREQ requesters.
// Stage 1 registers the granted sample, the converter is combinational on
// stage 1, and stage 2 registers the tagged result.
module fpcvt_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic            clk,
  input logic            rst_n,
  fpcvt_sched_if.slave   bus
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1Valid_q, s1Valid_d;
  logic [12:0]     s1Data_q, s1Data_d;
  logic [IDW-1:0]  s1Id_q, s1Id_d;
  logic            resValid_q, resValid_d;
  logic [IDW-1:0]  resId_q, resId_d;
  logic            resS_q, resS_d;
  logic [2:0]      resE_q, resE_d;
  logic [4:0]      resF_q, resF_d;

  logic            adv1, adv2;
  logic            grantFound;
  logic [IDW-1:0]  grantIdx;
  logic            grantTake;
  logic [NREQ-1:0] grantVec;
  logic [12:0]     grantData;

  logic [11:0]     cvtMag;
  logic [2:0]      cvtLead;
  logic [4:0]      cvtTrunc;
  logic            cvtRound;
  logic [5:0]      cvtRounded;
  logic            cvtS;
  logic [2:0]      cvtE;
  logic [4:0]      cvtF;

  assign adv2      = !resValid_q | bus.res_ready;
  assign adv1      = !s1Valid_q | adv2;
  assign grantTake = rst_n & adv1 & grantFound;

  // Round-robin search starting at ptr; scanning offsets downward lets the
  // closest valid index to ptr win.
  always_comb begin
    logic [IDW:0] idxW;
    grantFound = 1'b0;
    grantIdx   = '0;
    idxW       = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idxW = {1'b0, ptr_q} + (IDW+1)'(j);
      if (idxW >= (IDW+1)'(NREQ)) idxW = idxW - (IDW+1)'(NREQ);
      if (bus.req_valid[idxW[IDW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = idxW[IDW-1:0];
      end
    end
  end

  // One-hot grant and the granted sample; nothing is granted in reset or
  // while both stages are full and the consumer is stalling.
  always_comb begin
    grantVec  = '0;
    grantData = bus.req_data[13*int'(grantIdx) +: 13];
    if (grantTake) grantVec[grantIdx] = 1'b1;
  end

  // Converter: magnitude, leading-one position, round-half-up on the first
  // dropped bit, with saturation when rounding carries out of exponent 7.
  always_comb begin
    cvtS     = s1Data_q[12];
    cvtMag   = s1Data_q[12] ? (~s1Data_q[11:0] + 12'd1) : s1Data_q[11:0];
    cvtLead  = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      if (cvtMag[k+4]) cvtLead = 3'(k);
    end
    cvtTrunc   = 5'(cvtMag >> cvtLead);
    cvtRound   = |(cvtMag & ((12'd1 << cvtLead) >> 1));
    cvtRounded = {1'b0, cvtTrunc} + {5'd0, cvtRound};
    cvtE       = cvtLead;
    cvtF       = cvtRounded[4:0];
    if (cvtRounded[5]) begin
      if (cvtLead == 3'd7) begin
        cvtE = 3'd7;
        cvtF = 5'd31;
      end else begin
        cvtE = cvtLead + 3'd1;
        cvtF = cvtRounded[5:1];
      end
    end
    if (s1Data_q == 13'h1000) begin
      cvtS = 1'b1;
      cvtE = 3'd7;
      cvtF = 5'd31;
    end
  end

  // Next state for pointer and both pipeline stages; everything holds by
  // default so a stall needs no explicit branch.
  always_comb begin
    ptr_d      = ptr_q;
    s1Valid_d  = s1Valid_q;
    s1Data_d   = s1Data_q;
    s1Id_d     = s1Id_q;
    resValid_d = resValid_q;
    resId_d    = resId_q;
    resS_d     = resS_q;
    resE_d     = resE_q;
    resF_d     = resF_q;
    if (adv2) begin
      resValid_d = s1Valid_q;
      resId_d    = s1Id_q;
      resS_d     = cvtS;
      resE_d     = cvtE;
      resF_d     = cvtF;
    end
    if (adv1) begin
      s1Valid_d = grantTake;
    end
    if (grantTake) begin
      s1Data_d = grantData;
      s1Id_d   = grantIdx;
      if (grantIdx == IDW'(NREQ - 1)) ptr_d = '0;
      else                            ptr_d = grantIdx + 1'b1;
    end
  end

  // State registers; reset flushes both stages without emitting a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s1Valid_q  <= 1'b0;
      s1Data_q   <= '0;
      s1Id_q     <= '0;
      resValid_q <= 1'b0;
      resId_q    <= '0;
      resS_q     <= 1'b0;
      resE_q     <= '0;
      resF_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1Valid_q  <= s1Valid_d;
      s1Data_q   <= s1Data_d;
      s1Id_q     <= s1Id_d;
      resValid_q <= resValid_d;
      resId_q    <= resId_d;
      resS_q     <= resS_d;
      resE_q     <= resE_d;
      resF_q     <= resF_d;
    end
  end

  assign bus.req_ready = grantVec;
  assign bus.res_valid = resValid_q;
  assign bus.res_id    = resId_q;
  assign bus.res_s     = resS_q;
  assign bus.res_e     = resE_q;
  assign bus.res_f     = resF_q;
  assign bus.busy      = s1Valid_q | resValid_q;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Directed bench for fpcvt_sched: reset, round-robin order, conversion
// values, backpressure, fairness and mid-operation reset.
module tb_fpcvt_sched;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  fpcvt_sched_if #(.NREQ(4), .IDW(2)) busIf ();

  fpcvt_sched #(.NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSamples(input logic [12:0] d0, input logic [12:0] d1,
                            input logic [12:0] d2, input logic [12:0] d3);
    busIf.req_data = {d3, d2, d1, d0};
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic resReady);
    busIf.req_valid = valid;
    busIf.res_ready = resReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [1:0] id,
                             input logic s, input logic [2:0] e,
                             input logic [4:0] f);
    checkOutput({tag, "_valid"}, 32'(busIf.res_valid), 32'd1);
    checkOutput({tag, "_id"},    32'(busIf.res_id),    32'(id));
    checkOutput({tag, "_s"},     32'(busIf.res_s),     32'(s));
    checkOutput({tag, "_e"},     32'(busIf.res_e),     32'(e));
    checkOutput({tag, "_f"},     32'(busIf.res_f),     32'(f));
  endtask

  // Directed sequence.
  initial begin
    logic [3:0] fairA [4];
    logic [3:0] fairB [4];
    logic       rrS [4];
    logic [2:0] rrE [4];
    logic [4:0] rrF [4];

    nChecks = 0;
    nFails  = 0;
    rrS = '{1'b0, 1'b1, 1'b0, 1'b1};
    rrE = '{3'd2, 3'd0, 3'd1, 3'd7};
    rrF = '{5'd16, 5'd1, 5'd28, 5'd31};
    fairA = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    fairB = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

    // Reset state
    rst_n = 1'b0;
    setSamples(13'd0, 13'd0, 13'd0, 13'd0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rst_req_ready", 32'(busIf.req_ready), 32'd0);
    checkOutput("rst_res_valid", 32'(busIf.res_valid), 32'd0);
    checkOutput("rst_busy",      32'(busIf.busy),      32'd0);
    checkOutput("rst_res_id",    32'(busIf.res_id),    32'd0);
    checkOutput("rst_res_s",     32'(busIf.res_s),     32'd0);
    checkOutput("rst_res_e",     32'(busIf.res_e),     32'd0);
    checkOutput("rst_res_f",     32'(busIf.res_f),     32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b1);

    // All four requesters valid: grants 0,1,2,3,0,... and one result per cycle
    $display("[TB] round-robin with four requesters");
    setSamples(13'd63, 13'h1FFF, 13'd56, 13'h1000);
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rr_grant", 32'(busIf.req_ready), 32'(4'b0001 << (i % 4)));
      tick();
      if (i >= 1) checkResult("rr_result", 2'((i - 1) % 4), rrS[(i - 1) % 4],
                              rrE[(i - 1) % 4], rrF[(i - 1) % 4]);
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkResult("rr_last", 2'd3, 1'b1, 3'd7, 5'd31);
    tick();
    checkOutput("rr_drain_valid", 32'(busIf.res_valid), 32'd0);
    checkOutput("rr_drain_busy",  32'(busIf.busy),      32'd0);

    // Single requester 0, D=422, two-stage latency
    $display("[TB] single requester latency");
    setSamples(13'd422, 13'd0, 13'd0, 13'd0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_grant", 32'(busIf.req_ready), 32'b0001);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_mid_valid", 32'(busIf.res_valid), 32'd0);
    checkOutput("single_mid_busy",  32'(busIf.busy),      32'd1);
    tick();
    checkResult("single_result", 2'd0, 1'b0, 3'd4, 5'd26);
    tick();
    checkOutput("single_drain", 32'(busIf.res_valid), 32'd0);

    // Saturating edge value on requester 2
    $display("[TB] saturation edge value");
    setSamples(13'd0, 13'd0, 13'h0FFF, 13'd0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("sat_grant", 32'(busIf.req_ready), 32'b0100);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkResult("sat_result", 2'd2, 1'b0, 3'd7, 5'd31);
    tick();

    // Backpressure: pointer is at 3, fill both stages then stall 5 cycles
    $display("[TB] backpressure");
    setSamples(13'd100, 13'd200, 13'd300, 13'h1FFB);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("bp_grant_a", 32'(busIf.req_ready), 32'b1000);
    tick();
    checkOutput("bp_grant_b", 32'(busIf.req_ready), 32'b0001);
    tick();
    for (int h = 0; h < 5; h++) begin
      checkOutput("bp_hold_ready", 32'(busIf.req_ready), 32'd0);
      checkOutput("bp_hold_busy",  32'(busIf.busy),      32'd1);
      checkResult("bp_hold", 2'd3, 1'b1, 3'd0, 5'd5);
      tick();
    end
    checkResult("bp_hold_end", 2'd3, 1'b1, 3'd0, 5'd5);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("bp_release_grant", 32'(busIf.req_ready), 32'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkResult("bp_out0", 2'd0, 1'b0, 3'd2, 5'd25);
    tick();
    checkResult("bp_out1", 2'd1, 1'b0, 3'd3, 5'd25);
    tick();
    checkOutput("bp_drain", 32'(busIf.res_valid), 32'd0);

    // Pointer is at 2; one grant to 3 brings it back to 0
    setSamples(13'd0, 13'd0, 13'd0, 13'h0800);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("wrap_grant", 32'(busIf.req_ready), 32'b1000);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkResult("wrap_result", 2'd3, 1'b0, 3'd7, 5'd16);

    // Fairness: 1 and 3 alternate, then 2 joins
    $display("[TB] fairness");
    applyStimulus(4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fair_pair", 32'(busIf.req_ready), 32'(fairA[i]));
      tick();
    end
    applyStimulus(4'b1110, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fair_three", 32'(busIf.req_ready), 32'(fairB[i]));
      tick();
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    checkOutput("fair_idle", 32'(busIf.busy), 32'd0);

    // Reset while both stages hold data
    $display("[TB] reset mid-operation");
    setSamples(13'd0, 13'd422, 13'd300, 13'd0);
    applyStimulus(4'b0010, 1'b0);
    tick();
    tick();
    checkOutput("full_busy",  32'(busIf.busy),      32'd1);
    checkOutput("full_valid", 32'(busIf.res_valid), 32'd1);
    checkOutput("full_ready", 32'(busIf.req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(busIf.res_valid), 32'd0);
    checkOutput("async_rst_busy",  32'(busIf.busy),      32'd0);
    checkOutput("async_rst_ready", 32'(busIf.req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b0110, 1'b1);
    checkOutput("post_rst_grant", 32'(busIf.req_ready), 32'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkResult("post_rst_result", 2'd1, 1'b0, 3'd4, 5'd26);
    tick();
    checkOutput("post_rst_idle", 32'(busIf.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
